// File: rtl/trace_msg_arbiter.sv
// trace_msg_arbiter: round-robin arbiter that lets one of NUM_REQ requesters
// own a shared message channel for a whole packet, with a hard cap of
// MAX_BEATS beats per packet (longer packets are cut and flagged).
//
// Handshake: a beat moves on any channel when valid and ready are both high
// at a rising clock edge. Valid never waits on ready. While a packet is in
// flight only the owner's req_ready follows out_ready. Every other
// req_ready is held low.
//
// The FSM state is visible on busy (busy = XFER).
module trace_msg_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BEATS = 16,
  localparam int ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CNT_W    = $clog2(MAX_BEATS) + 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cfg_master_en,
  input  logic [NUM_REQ-1:0]          cfg_en,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  input  logic [NUM_REQ-1:0]          req_last,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        out_valid,
  output logic [DATA_W-1:0]           out_data,
  output logic                        out_last,
  input  logic                        out_ready,
  output logic [ID_W-1:0]             gnt_id,
  output logic                        busy,
  output logic                        trunc_sticky
);

  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

  state_t               state;
  state_t               state_next;
  logic [ID_W-1:0]      rr_ptr;
  logic [ID_W-1:0]      pick_idx;
  logic [ID_W-1:0]      cand;
  logic                 pick_found;
  logic [CNT_W-1:0]     beat_cnt;
  logic [NUM_REQ-1:0]   eligible;
  logic                 forced_last;
  logic                 accept;
  logic [DATA_W-1:0]    data_arr [NUM_REQ];

  // Unpack the flat data bus so the owner's beat can be picked by index.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      data_arr[i] = req_data[i*DATA_W +: DATA_W];
    end
  end

  assign eligible = req_valid & cfg_en & {NUM_REQ{cfg_master_en}};
  assign busy     = (state == XFER);

  // Pick the first eligible requester at or after rr_ptr, wrapping around.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
      if (!pick_found && eligible[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and channel muxing. The channel stays quiet in IDLE. In XFER it
  // mirrors the owner. The cap forces out_last on the final allowed beat.
  always_comb begin
    state_next  = state;
    out_valid   = 1'b0;
    out_data    = '0;
    out_last    = 1'b0;
    req_ready   = '0;
    accept      = 1'b0;
    forced_last = 1'b0;
    case (state)
      IDLE: begin
        if (pick_found) begin
          state_next = XFER;
        end
      end
      XFER: begin
        forced_last       = (beat_cnt == CNT_W'(MAX_BEATS - 1));
        out_valid         = req_valid[gnt_id];
        out_data          = data_arr[gnt_id];
        out_last          = req_last[gnt_id] | forced_last;
        req_ready[gnt_id] = out_ready;
        accept            = out_valid & out_ready;
        if (accept && out_last) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Grant, round-robin pointer, beat counter and truncation flag. The pointer
  // moves only when a packet completes. A reset mid-packet restarts at 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_id       <= '0;
      rr_ptr       <= '0;
      beat_cnt     <= '0;
      trunc_sticky <= 1'b0;
    end else begin
      if (state == IDLE && pick_found) begin
        gnt_id   <= pick_idx;
        beat_cnt <= '0;
      end else if (accept) begin
        beat_cnt <= beat_cnt + 1'b1;
        if (out_last) begin
          rr_ptr <= (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
        end
        if (forced_last) begin
          trunc_sticky <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_trace_msg_arbiter.sv
// Bench for trace_msg_arbiter. Each requester is a beat source backed by a
// memory of queued beats. A packet-level model tracks the owner, the beat
// count, the round-robin pointer and the sticky flag. It predicts the channel
// on every falling edge. Directed scenarios pin the model with literal
// expectations. A random phase follows.
module tb_trace_msg_arbiter;
  localparam int N   = 4;
  localparam int W   = 8;
  localparam int MB  = 16;
  localparam int IDW = 2;
  localparam int MEM = 4096;

  logic           clk = 1'b0;
  logic           rst;
  logic           cfg_master_en;
  logic [N-1:0]   cfg_en;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic           out_last;
  logic           out_ready;
  logic [IDW-1:0] gnt_id;
  logic           busy;
  logic           trunc_sticky;

  int tests = 0;
  int fails = 0;

  // Beat sources: {last, data} entries, consumed from head.
  logic [W:0]   src_mem [N][MEM];
  int           head [N];
  int           tail [N];
  logic [N-1:0] gate;
  logic [N-1:0] acc_mask;
  bit           rand_mode;

  // Scoreboard and observed-beat log.
  logic [W:0] exp_q [$];
  logic [W:0] obs_q [$];

  // Packet-level model.
  int m_owner;
  int m_cnt;
  int m_rr;
  bit m_trunc;

  trace_msg_arbiter #(.NUM_REQ(N), .DATA_W(W), .MAX_BEATS(MB)) dut (
    .clk(clk), .rst(rst), .cfg_master_en(cfg_master_en), .cfg_en(cfg_en),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .out_valid(out_valid), .out_data(out_data),
    .out_last(out_last), .out_ready(out_ready), .gnt_id(gnt_id),
    .busy(busy), .trunc_sticky(trunc_sticky)
  );

  // Clock generation.
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic add_pkt(input int i, input int len, input logic [W-1:0] base);
    for (int k = 0; k < len; k++) begin
      src_mem[i][tail[i]] = {(k == len - 1), base + W'(k)};
      tail[i]++;
    end
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      logic [W:0] h;
      h = src_mem[i][head[i]];
      req_valid[i]       = (head[i] < tail[i]) && gate[i];
      req_data[i*W +: W] = h[W-1:0];
      req_last[i]        = h[W];
    end
  endtask

  task automatic rand_knobs();
    for (int i = 0; i < N; i++) begin
      if ((tail[i] - head[i]) < 4 && $urandom_range(0, 7) == 0)
        add_pkt(i, int'($urandom_range(1, 20)), W'($urandom));
      gate[i] = ($urandom_range(0, 7) != 0);
    end
    out_ready     = ($urandom_range(0, 3) != 0);
    cfg_master_en = ($urandom_range(0, 31) != 0);
    if ($urandom_range(0, 15) == 0) cfg_en = N'($urandom);
  endtask

  // One clock: pop accepted beats, then drive new inputs 2 units after the edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
      for (int i = 0; i < N; i++) if (acc_mask[i]) head[i]++;
      if (rand_mode) rand_knobs();
      drive_inputs();
    end
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < N; i++) if (head[i] < tail[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_drain(input string name, input int budget);
    int k;
    k = 0;
    while (k < budget && !(all_empty() && m_owner < 0)) begin
      step(1);
      k++;
    end
    chk(name, (k < budget), 1);
  endtask

  task automatic chk_obs(input string name, input logic [W:0] exp [$]);
    chk({name, "_count"}, obs_q.size(), exp.size());
    for (int k = 0; k < exp.size() && k < obs_q.size(); k++)
      chk($sformatf("%s_beat%0d", name, k), obs_q[k], exp[k]);
  endtask

  // Compare process: predict the channel from the model, compare, then advance
  // the model to what the next rising edge will do.
  always @(negedge clk) begin
    logic [N-1:0] e_ready;
    logic [N-1:0] elig;
    logic         e_valid;
    logic         e_last;
    logic [W-1:0] e_data;
    int           c;
    if (rst) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_trunc", trunc_sticky, 0);
      chk("rst_gnt_id", gnt_id, 0);
      m_owner  = -1;
      m_cnt    = 0;
      m_rr     = 0;
      m_trunc  = 1'b0;
      acc_mask = '0;
    end else begin
      e_ready = '0;
      e_valid = 1'b0;
      e_last  = 1'b0;
      e_data  = '0;
      if (m_owner >= 0) begin
        e_valid          = req_valid[m_owner];
        e_data           = req_data[m_owner*W +: W];
        e_last           = req_last[m_owner] || (m_cnt == MB - 1);
        e_ready[m_owner] = out_ready;
      end
      chk("out_valid", out_valid, e_valid);
      chk("busy", busy, (m_owner >= 0));
      chk("req_ready", req_ready, e_ready);
      chk("trunc_sticky", trunc_sticky, m_trunc);
      if (m_owner >= 0) chk("gnt_id", gnt_id, m_owner);
      if (e_valid && out_ready) exp_q.push_back({e_last, e_data});
      if (out_valid && out_ready) begin
        obs_q.push_back({out_last, out_data});
        if (exp_q.size() == 0) chk("unexpected_beat", {out_last, out_data}, 32'hFFFF_FFFF);
        else chk("beat", {out_last, out_data}, exp_q.pop_front());
      end
      acc_mask = req_valid & req_ready;
      if (m_owner < 0) begin
        elig = req_valid & cfg_en & {N{cfg_master_en}};
        for (int k = 0; k < N; k++) begin
          c = (m_rr + k) % N;
          if (m_owner < 0 && elig[c]) begin
            m_owner = c;
            m_cnt   = 0;
          end
        end
      end else if (e_valid && out_ready) begin
        if (e_last) begin
          if (m_cnt == MB - 1) m_trunc = 1'b1;
          m_rr    = (m_owner + 1) % N;
          m_owner = -1;
        end
        m_cnt++;
      end
    end
  end

  // Stimulus and final report.
  initial begin
    logic [W:0] ev [$];
    int k;
    rst           = 1'b1;
    cfg_master_en = 1'b1;
    cfg_en        = '1;
    out_ready     = 1'b1;
    gate          = '1;
    rand_mode     = 1'b0;
    acc_mask      = '0;
    m_owner       = -1;
    for (int i = 0; i < N; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    drive_inputs();
    step(2);
    chk("init_out_valid", out_valid, 0);
    chk("init_busy", busy, 0);
    chk("init_gnt", gnt_id, 0);
    rst = 1'b0;

    // Requesters 0 and 2, two-beat packets: 0 first, then 2, leaving rr at 3.
    obs_q.delete();
    add_pkt(0, 2, 8'h10);
    add_pkt(2, 2, 8'h20);
    drive_inputs();
    wait_drain("a_drain", 50);
    ev = '{9'h010, 9'h111, 9'h020, 9'h121};
    chk_obs("a_order", ev);
    obs_q.delete();
    add_pkt(0, 1, 8'h30);
    add_pkt(3, 1, 8'h40);
    drive_inputs();
    wait_drain("a2_drain", 50);
    ev = '{9'h140, 9'h130};
    chk_obs("a2_rr_at_3", ev);

    // Disabled requester is not granted until its enable bit returns.
    cfg_en = 4'b1011;
    add_pkt(2, 1, 8'h50);
    drive_inputs();
    step(5);
    chk("b_blocked_valid", out_valid, 0);
    chk("b_blocked_busy", busy, 0);
    cfg_en = 4'b1111;
    drive_inputs();
    step(1);
    chk("b_grant_busy", busy, 1);
    chk("b_grant_id", gnt_id, 2);
    wait_drain("b_drain", 50);

    // A 20-beat packet is cut after beat 16, and the last 4 beats form a new packet.
    chk("c_trunc_before", trunc_sticky, 0);
    obs_q.delete();
    add_pkt(1, 20, 8'h60);
    drive_inputs();
    wait_drain("c_drain", 100);
    chk("c_count", obs_q.size(), 20);
    if (obs_q.size() == 20) begin
      chk("c_beat15_last", obs_q[14][W], 0);
      chk("c_beat16_last", obs_q[15][W], 1);
      chk("c_beat17", obs_q[16], 9'h070);
      chk("c_beat20_last", obs_q[19], 9'h173);
    end
    chk("c_trunc_after", trunc_sticky, 1);

    // out_ready alternates during a 4-beat packet. All 4 beats arrive in order.
    obs_q.delete();
    add_pkt(3, 4, 8'hB0);
    drive_inputs();
    for (int j = 0; j < 12; j++) begin
      out_ready = (j % 2 == 0);
      drive_inputs();
      step(1);
    end
    out_ready = 1'b1;
    drive_inputs();
    wait_drain("d_drain", 50);
    ev = '{9'h0B0, 9'h0B1, 9'h0B2, 9'h1B3};
    chk_obs("d_stall", ev);

    // All requesters are continuously busy with 1-beat packets: grants rotate 0,1,2,3,0,...
    obs_q.delete();
    for (int i = 0; i < N; i++) begin
      add_pkt(i, 1, W'(8'h80 + 2 * i));
      add_pkt(i, 1, W'(8'h81 + 2 * i));
    end
    drive_inputs();
    wait_drain("e_drain", 100);
    ev = '{9'h180, 9'h182, 9'h184, 9'h186, 9'h181, 9'h183, 9'h185, 9'h187};
    chk_obs("e_rotate", ev);

    // Reset during beat 3 of a requester-3 packet. Arbitration restarts at 0.
    add_pkt(1, 1, 8'h90);
    drive_inputs();
    wait_drain("f_pre_drain", 50);
    obs_q.delete();
    add_pkt(3, 6, 8'hC0);
    drive_inputs();
    k = 0;
    while (obs_q.size() < 2 && k < 50) begin
      step(1);
      k++;
    end
    chk("f_reach_beat3", obs_q.size(), 2);
    rst = 1'b1;
    #1;
    chk("f_rst_out_valid", out_valid, 0);
    chk("f_rst_busy", busy, 0);
    step(2);
    rst = 1'b0;
    obs_q.delete();
    add_pkt(0, 1, 8'hA0);
    drive_inputs();
    step(1);
    chk("f_regrant_busy", busy, 1);
    chk("f_regrant_id", gnt_id, 0);
    wait_drain("f_drain", 50);
    chk("f_first_after_rst", (obs_q.size() > 0) ? obs_q[0] : '0, 9'h1A0);
    chk("f_resumed_beat", (obs_q.size() > 1) ? obs_q[1] : '0, 9'h0C2);

    // Random phase.
    rand_mode = 1'b1;
    step(3000);
    rand_mode     = 1'b0;
    gate          = '1;
    cfg_en        = '1;
    cfg_master_en = 1'b1;
    out_ready     = 1'b1;
    drive_inputs();
    wait_drain("rand_drain", 2000);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/trace_msg_arbiter.md
TRACE_MSG_ARBITER -- requirements
Module: trace_msg_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of message requesters.
REQ-002 Parameter DATA_W, default 8, message beat width in bits.
REQ-003 Parameter MAX_BEATS, default 16, maximum beats per packet before forced termination.
REQ-004 Port clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port rst  input  1  asynchronous, active-high reset.
REQ-006 Port cfg_master_en  input  1  global enable; 0 blocks all new grants.
REQ-007 Port cfg_en  input  NUM_REQ  per-requester enable mask; grant only if master and own bit both 1.
REQ-008 Port req_valid  input  NUM_REQ  per-requester beat valid.
REQ-009 Port req_data  input  NUM_REQ*DATA_W  packed beats, requester i at bits [i*DATA_W +: DATA_W].
REQ-010 Port req_last  input  NUM_REQ  per-requester last-beat flag.
REQ-011 Port req_ready  output  NUM_REQ  per-requester beat accept.
REQ-012 Port out_valid / out_data / out_last  output  1 / DATA_W / 1  shared message channel.
REQ-013 Port out_ready  input  1  downstream accept.
REQ-014 Port gnt_id  output  clog2(NUM_REQ)  index of requester currently owning the channel.
REQ-015 Port busy  output  1  high while in XFER state.
REQ-016 Port trunc_sticky  output  1  set when any packet is force-terminated at MAX_BEATS; cleared only by reset.

Function
REQ-017 FSM SHALL have two states: IDLE, XFER.
REQ-018 Eligible set = req_valid & cfg_en & {NUM_REQ{cfg_master_en}}.
REQ-019 In IDLE with nonempty eligible set, SHALL select first eligible index at or after rr_ptr (wrapping NUM_REQ-1 -> 0), register it to gnt_id, enter XFER next edge.
REQ-020 In IDLE: out_valid=0, req_ready all 0; no beat accepted.
REQ-021 In XFER: out_valid=req_valid[gnt_id], out_data=req_data[gnt_id], out_last=req_last[gnt_id] OR forced-last; req_ready[gnt_id]=out_ready, all other req_ready 0.
REQ-022 Beat accepted when out_valid & out_ready; beat counter (width clog2(MAX_BEATS)+1) increments per accepted beat, clears on XFER entry.
REQ-023 Forced-last SHALL assert when beat counter == MAX_BEATS-1; accepting that beat ends the packet and sets trunc_sticky.
REQ-024 Accepted beat with out_last=1 SHALL return FSM to IDLE and set rr_ptr = gnt_id+1 modulo NUM_REQ.
REQ-025 Minimum one IDLE cycle between packets; first beat of a packet appears on out_* no earlier than the cycle after the request is sampled in IDLE.
REQ-026 Clearing cfg_en bit or cfg_master_en during XFER SHALL NOT abort the packet; it affects only subsequent arbitration.
REQ-027 Granted requester dropping req_valid mid-packet: out_valid=0, FSM holds XFER, counter holds.
REQ-028 out_ready low: all outputs hold, counter holds, no state change.
REQ-029 Non-granted requesters SHALL be starved no longer than NUM_REQ-1 packets while eligible.

Reset
REQ-030 On rst=1, asynchronously: state=IDLE, rr_ptr=0, gnt_id=0, beat counter=0, trunc_sticky=0, busy=0, out_valid=0, req_ready=0.
REQ-031 Reset asserted mid-packet SHALL drop the packet without completing it; after release, arbitration restarts from requester 0.

Verification
REQ-032 Req 0 and 2 valid, all enabled, 2-beat packets, out_ready=1 -> req 0 packet, 1 IDLE cycle, req 2 packet, then rr_ptr=3.
REQ-033 cfg_en=4'b1011, req 2 only valid -> no grant, out_valid stays 0; set cfg_en[2] -> grant gnt_id=2 next cycle.
REQ-034 Req 1 sends 20-beat packet, MAX_BEATS=16 -> out_last on beat 16, trunc_sticky=1, FSM IDLE, remaining beats arbitrate as new packet.
REQ-035 out_ready toggling 1010 during 4-beat packet -> out_data stable while stalled, exactly 4 accepts, order preserved.
REQ-036 All 4 requesters continuously valid, 1-beat packets -> grants 0,1,2,3,0 in order.
REQ-037 rst pulsed during beat 3 of req 3 packet -> out_valid=0 immediately, busy=0, next grant considers requester 0 first.
